// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 bus bundle used by wb_burst_reader; clk and rst travel with the bus.
interface wshb_if;
    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (
        input  clk, rst, dat_sm, ack,
        output adr, dat_ms, we, sel, cyc, stb, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, we, sel, cyc, stb, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/wb_burst_reader.sv
// Reads a circular word region over Wishbone in BURST_LEN-word grants into a show-ahead FIFO.
// Define WB_BURST_READER_BURST_EN for incrementing bursts (cti 010/111); otherwise classic single cycles.
module wb_burst_reader #(
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int unsigned NWORDS     = 2048,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    wshb_if.master                       wb_m,
    input  logic                         enable,
    input  logic                         restart,
    input  logic                         rd_en,
    output logic [31:0]                  rd_data,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  level
);
    localparam int unsigned AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BW = $clog2(BURST_LEN);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    if (NWORDS == 0 || (NWORDS % BURST_LEN) != 0) begin : g_chk_nwords
        $error("wb_burst_reader: NWORDS must be a nonzero multiple of BURST_LEN");
    end
    if (BURST_LEN < 2 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_chk_burst
        $error("wb_burst_reader: BURST_LEN must be a power of two, at least 2");
    end
    if (FIFO_DEPTH < BURST_LEN) begin : g_chk_depth
        $error("wb_burst_reader: FIFO_DEPTH must be at least BURST_LEN");
    end

`ifdef WB_BURST_READER_BURST_EN
    localparam logic [2:0] CTI_FIRST = 3'b010;
`else
    localparam logic [2:0] CTI_FIRST = 3'b000;
`endif

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   word_idx_q, word_idx_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            restart_pend_q, restart_pend_d;
    logic            cyc_q, cyc_d;
    logic [2:0]      cti_q, cti_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            ack_v;
    logic            push;
    logic            pop;
    logic            flush;
    logic [AW-1:0]   next_idx;

    always_comb begin
        state_d        = state_q;
        word_idx_d     = word_idx_q;
        beat_d         = beat_q;
        restart_pend_d = restart_pend_q;
        cyc_d          = cyc_q;
        cti_d          = cti_q;
        push           = 1'b0;
        flush          = 1'b0;
        ack_v          = cyc_q && wb_m.ack;
        next_idx       = (word_idx_q == AW'(NWORDS - 1)) ? '0 : word_idx_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (restart || restart_pend_q) begin
                    flush          = 1'b1;
                    word_idx_d     = '0;
                    restart_pend_d = 1'b0;
                end else if (enable && count_q <= LW'(FIFO_DEPTH - BURST_LEN)) begin
                    state_d = BURST;
                    cyc_d   = 1'b1;
                    beat_d  = '0;
                    cti_d   = CTI_FIRST;
                end
            end
            BURST: begin
                if (restart) begin
                    restart_pend_d = 1'b1;
                end
                if (ack_v) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        cyc_d   = 1'b0;
                        cti_d   = 3'b000;
                        // A restart seen anywhere in the burst drops the final word and rewinds here.
                        if (restart || restart_pend_q) begin
                            flush          = 1'b1;
                            word_idx_d     = '0;
                            restart_pend_d = 1'b0;
                        end else begin
                            push       = 1'b1;
                            word_idx_d = next_idx;
                        end
                    end else begin
                        push       = 1'b1;
                        word_idx_d = next_idx;
`ifdef WB_BURST_READER_BURST_EN
                        cti_d = (beat_q == BW'(BURST_LEN - 2)) ? 3'b111 : 3'b010;
`else
                        cyc_d = 1'b0;
`endif
                    end
                end else if (!cyc_q) begin
                    cyc_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            state_q        <= IDLE;
            word_idx_q     <= '0;
            beat_q         <= '0;
            restart_pend_q <= 1'b0;
            cyc_q          <= 1'b0;
            cti_q          <= 3'b000;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            beat_q         <= beat_d;
            restart_pend_q <= restart_pend_d;
            cyc_q          <= cyc_d;
            cti_q          <= cti_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge wb_m.clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wb_m.dat_sm;
        end
    end

    assign wb_m.adr    = BASE_ADR + 32'({word_idx_q, 2'b00});
    assign wb_m.dat_ms = '0;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = '1;
    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = cyc_q;
    assign wb_m.cti    = cti_q;
    assign wb_m.bte    = 2'b00;

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign level   = count_q;
endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: BRAM slave with mem[i]=i, queue model, directed phases.
module tb_wb_burst_reader;
    localparam logic [31:0] BASE = 32'h0;
    localparam int NW = 2048;
    localparam int BL = 8;
    localparam int FD = 16;
`ifdef WB_BURST_READER_BURST_EN
    localparam bit BURST_MODE = 1'b1;
`else
    localparam bit BURST_MODE = 1'b0;
`endif

    wshb_if wb();

    logic        enable;
    logic        restart;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        empty;
    logic [4:0]  level;

    wb_burst_reader #(
        .BASE_ADR   (BASE),
        .NWORDS     (NW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD)
    ) dut (
        .wb_m    (wb.master),
        .enable  (enable),
        .restart (restart),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .level   (level)
    );

    initial wb.clk = 1'b0;
    always #5 wb.clk = ~wb.clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // BRAM slave: word i holds i; one ack per two cycles, optional extra stalls
    logic [31:0] mem [NW];
    bit          stall_en = 1'b0;
    int unsigned cyc_cnt  = 0;
    initial for (int i = 0; i < NW; i++) mem[i] = 32'(i);

    always @(posedge wb.clk) begin
        cyc_cnt   <= cyc_cnt + 1;
        wb.dat_sm <= mem[wb.adr[12:2]];
        if (wb.rst) wb.ack <= 1'b0;
        else wb.ack <= wb.cyc && wb.stb && !wb.ack && (!stall_en || (cyc_cnt % 3) == 0);
    end

    // Model state: expected FIFO contents and burst bookkeeping
    logic [31:0] q[$];
    int          m_idx   = 0;
    bit          m_busy  = 1'b0;
    int          m_beats = 0;
    bit          m_pend  = 1'b0;
    bit          m_gap   = 1'b0;
    int          ack_cnt = 0;
    bit          chk_on  = 1'b0;
    bit          log_on  = 1'b0;
    logic [2:0]  cti_log[$];
    int          gap_cnt = 0;
    logic [31:0] max_adr = '0;
    bit          stream_on  = 1'b0;
    int          stream_cnt = 0;
    logic [31:0] exp_stream = '0;

    always @(negedge wb.clk) begin : compare
        bit exp_cyc, do_pop, push, flush;
        exp_cyc = m_busy && !m_gap;
        do_pop  = rd_en && (q.size() > 0);
        push    = 1'b0;
        flush   = 1'b0;
        if (chk_on) begin
            check("cyc", 32'(wb.cyc), 32'(exp_cyc));
            check("stb", 32'(wb.stb), 32'(exp_cyc));
            check("level", 32'(level), 32'(q.size()));
            check("empty", 32'(empty), 32'(q.size() == 0));
            if (q.size() > 0) check("rd_data", rd_data, q[0]);
            if (wb.cyc) begin
                check("adr", wb.adr, BASE + 32'(4 * m_idx));
                check("cti", 32'(wb.cti), BURST_MODE ? ((m_beats == BL - 1) ? 32'd7 : 32'd2) : 32'd0);
                check("dat_ms", wb.dat_ms, 32'd0);
                check("we_sel_bte", {25'd0, wb.we, wb.sel, wb.bte}, {25'd0, 1'b0, 4'hF, 2'b00});
            end
            if (stream_on && do_pop) begin
                check("stream", rd_data, exp_stream);
                exp_stream = (exp_stream + 1) % NW;
                stream_cnt++;
            end
            if (log_on) begin
                if (wb.cyc && wb.ack) cti_log.push_back(wb.cti);
                if (m_busy && !wb.cyc) gap_cnt++;
                if (wb.cyc && wb.adr > max_adr) max_adr = wb.adr;
            end
        end
        m_gap = 1'b0;
        if (wb.rst) begin
            q.delete();
            m_idx = 0; m_busy = 1'b0; m_beats = 0; m_pend = 1'b0;
        end else begin
            if (!m_busy) begin
                if (restart) begin
                    flush = 1'b1; m_idx = 0; m_pend = 1'b0;
                end else if (enable && (FD - q.size()) >= BL) begin
                    m_busy = 1'b1; m_beats = 0;
                end
            end else begin
                if (restart) m_pend = 1'b1;
                if (exp_cyc && wb.ack) begin
                    ack_cnt++;
                    m_beats++;
                    if (m_beats == BL) begin
                        m_busy = 1'b0;
                        if (m_pend) begin
                            flush = 1'b1; m_idx = 0; m_pend = 1'b0;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        push  = 1'b1;
                        m_gap = !BURST_MODE;
                    end
                end
            end
            if (do_pop) void'(q.pop_front());
            if (push) begin
                q.push_back(32'(m_idx));
                m_idx = (m_idx + 1) % NW;
            end
            if (flush) q.delete();
        end
    end

    task automatic tick();
        @(posedge wb.clk);
        #1;
    endtask

    initial begin
        int a0;
        wb.rst = 1'b1; enable = 1'b0; restart = 1'b0; rd_en = 1'b0;
        repeat (3) tick();
        chk_on = 1'b1;
        wb.rst = 1'b0;
        check("reset_level", 32'(level), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_cyc", 32'(wb.cyc), 32'd0);
        check("reset_cti", 32'(wb.cti), 32'd0);

        // Fill with no reader: exactly two bursts, 0x00..0x3C
        log_on = 1'b1;
        a0 = ack_cnt;
        enable = 1'b1;
        for (int i = 0; i < 300 && ack_cnt - a0 < 16; i++) tick();
        repeat (30) tick();
        log_on = 1'b0;
        check("fill_acks", 32'(ack_cnt - a0), 32'd16);
        check("fill_level", 32'(level), 32'd16);
        check("model_level", 32'(q.size()), 32'd16);
        check("fill_max_adr", max_adr, 32'h3C);
        check("cti_log_len", 32'(cti_log.size()), 32'd16);
        for (int i = 0; i < 8; i++)
            check("cti_seq", 32'(cti_log[i]), BURST_MODE ? ((i == 7) ? 32'd7 : 32'd2) : 32'd0);
        check("classic_gaps", 32'(gap_cnt), BURST_MODE ? 32'd0 : 32'd14);

        enable = 1'b0;
        rd_en  = 1'b1;
        repeat (20) tick();
        rd_en = 1'b0;
        check("drained_level", 32'(level), 32'd0);

        // Restart during the 4th beat of the burst at words 16..23
        a0 = ack_cnt;
        enable = 1'b1;
        for (int i = 0; i < 100 && ack_cnt - a0 < 3; i++) tick();
        restart = 1'b1;
        enable  = 1'b0;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 100 && ack_cnt - a0 < 8; i++) tick();
        repeat (3) tick();
        check("restart_beats", 32'(ack_cnt - a0), 32'd8);
        check("restart_level", 32'(level), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 20 && !wb.cyc; i++) tick();
        check("restart_cyc_seen", 32'(wb.cyc), 32'd1);
        check("restart_adr", wb.adr, BASE);

        // Streaming with slave wait states, then reset during beat 3
        stall_en = 1'b1;
        rd_en    = 1'b1;
        repeat (100) tick();
        for (int i = 0; i < 200 && !(m_busy && m_beats == 2); i++) tick();
        check("busy_before_reset", 32'(m_idx != 0), 32'd1);
        wb.rst = 1'b1;
        tick();
        check("rst_cyc", 32'(wb.cyc), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        wb.rst = 1'b0;
        for (int i = 0; i < 20 && !wb.cyc; i++) tick();
        check("rst_cyc_seen", 32'(wb.cyc), 32'd1);
        check("rst_next_adr", wb.adr, BASE);
        stall_en = 1'b0;

        // Full-region stream from word 0, across the wrap
        enable = 1'b0;
        rd_en  = 1'b0;
        for (int i = 0; i < 200 && m_busy; i++) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();
        check("pre_stream_level", 32'(level), 32'd0);
        exp_stream = '0;
        stream_cnt = 0;
        stream_on  = 1'b1;
        enable     = 1'b1;
        rd_en      = 1'b1;
        for (int i = 0; i < 20000 && stream_cnt < NW + 2; i++) tick();
        stream_on = 1'b0;
        rd_en     = 1'b0;
        enable    = 1'b0;
        check("stream_count", 32'(stream_cnt), 32'(NW + 2));
        repeat (40) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
